// File: rtl/weight_lfsr_pkg.sv
// Shared constants, command opcodes and sequencer state encoding for the
// weight LFSR bank and its sequencer.
package weight_lfsr_pkg;

  localparam int unsigned N_R     = 81;
  localparam int unsigned FXP     = 6;
  localparam int unsigned N_L     = 16;
  localparam int unsigned N_SEED  = 26;
  localparam int unsigned N_L_REG = $clog2(N_SEED);
  localparam int unsigned N_RD    = N_R * FXP;
  localparam int unsigned RA_W    = $clog2(N_RD);

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_COMPUTE = 2'd1,
    OP_READ    = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMP,
    ST_READ
  } state_t;

endpackage

// File: rtl/seq_counter.sv
// Loadable up-counter with terminal flag; clear wins over increment, and the
// caller stops incrementing at the terminal value so it never wraps.
module seq_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last_val,
  output logic [W-1:0] q,
  output logic         at_last
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= '0;
    else if (inc)   q <= q + 1'b1;
  end

  assign at_last = (q == last_val);

endmodule

// File: rtl/weight_lfsr_seq_ctrl.sv
// Command sequencer for the 81-row weight LFSR bank: seed load, free-run
// compute and one-hot read sweep, with every bank-facing output registered.
module weight_lfsr_seq_ctrl
  import weight_lfsr_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic               cmd_opt,
  input  logic               seed_valid,
  output logic               seed_ready,
  input  logic [N_L-1:0]     seed_data,
  output logic               lfsr_load,
  output logic [N_L_REG-1:0] lfsr_sel,
  output logic [N_L-1:0]     LFSR_REG_INIT,
  output logic               lfsr_en,
  output logic               lfsr_option_sel,
  output logic               compute_en,
  output logic               read_en,
  output logic [RA_W-1:0]    READ_ADDR,
  output logic               busy,
  output logic               done,
  output logic               cmd_err
);

  state_t               state_q, state_n;
  logic                 drain_q, drain_n;
  logic [LEN_W-1:0]     len_q, len_n;

  logic                 opt_n, load_n, comp_n, read_n, done_n, err_n;
  logic [N_L_REG-1:0]   sel_n;
  logic [N_L-1:0]       init_n;

  logic                 accept, beat;
  logic [N_L_REG-1:0]   seed_q;
  logic                 seed_last, comp_last, rd_last;
  logic [LEN_W-1:0]     comp_q;
  logic                 in_comp, in_read;

  // cmd_ready / seed_ready are registered copies of the state, so the
  // handshakes only need the registered flags.
  assign accept  = cmd_valid & cmd_ready;
  assign beat    = seed_valid & seed_ready;
  assign in_comp = (state_q == ST_COMP);
  assign in_read = (state_q == ST_READ);

  seq_counter #(.W(N_L_REG)) u_seed_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (accept),
    .inc      (beat & ~seed_last),
    .last_val (N_L_REG'(N_SEED - 1)),
    .q        (seed_q),
    .at_last  (seed_last)
  );

  seq_counter #(.W(LEN_W)) u_comp_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (accept),
    .inc      (in_comp & ~comp_last),
    .last_val (len_q),
    .q        (comp_q),
    .at_last  (comp_last)
  );

  // The read counter is the address register itself; clearing it on the
  // terminal cycle returns READ_ADDR to 0 together with the done pulse.
  seq_counter #(.W(RA_W)) u_rd_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .clr      (accept | (in_read & rd_last)),
    .inc      (in_read & ~rd_last),
    .last_val (RA_W'(N_RD - 1)),
    .q        (READ_ADDR),
    .at_last  (rd_last)
  );

  always_comb begin
    state_n = state_q;
    drain_n = drain_q;
    len_n   = len_q;
    opt_n   = lfsr_option_sel;
    load_n  = 1'b0;
    sel_n   = lfsr_sel;
    init_n  = LFSR_REG_INIT;
    comp_n  = 1'b0;
    read_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opt_n   = cmd_opt;
          len_n   = cmd_len;
          drain_n = 1'b0;
          case (op_t'(cmd_op))
            OP_LOAD:    state_n = ST_LOAD;
            OP_COMPUTE: begin state_n = ST_COMP; comp_n = 1'b1; end
            OP_READ:    begin state_n = ST_READ; read_n = 1'b1; end
            default:    begin err_n = 1'b1; done_n = 1'b1; end
          endcase
        end
      end
      // After the last seed beat LOAD lingers one cycle with seed_ready low so
      // the final lfsr_load strobe stays inside LOAD and done lands after it.
      ST_LOAD: begin
        if (drain_q) begin
          state_n = ST_IDLE;
          drain_n = 1'b0;
          done_n  = 1'b1;
        end else if (beat) begin
          load_n = 1'b1;
          sel_n  = seed_q;
          init_n = seed_data;
          if (seed_last) drain_n = 1'b1;
        end
      end
      ST_COMP: begin
        if (comp_last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          comp_n = 1'b1;
        end
      end
      ST_READ: begin
        if (rd_last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          read_n = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q         <= ST_IDLE;
      drain_q         <= 1'b0;
      len_q           <= '0;
      cmd_ready       <= 1'b0;
      seed_ready      <= 1'b0;
      lfsr_load       <= 1'b0;
      lfsr_sel        <= '0;
      LFSR_REG_INIT   <= '0;
      lfsr_en         <= 1'b0;
      lfsr_option_sel <= 1'b0;
      compute_en      <= 1'b0;
      read_en         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      cmd_err         <= 1'b0;
    end else begin
      state_q         <= state_n;
      drain_q         <= drain_n;
      len_q           <= len_n;
      cmd_ready       <= (state_n == ST_IDLE);
      seed_ready      <= (state_n == ST_LOAD) && !drain_n;
      lfsr_load       <= load_n;
      lfsr_sel        <= sel_n;
      LFSR_REG_INIT   <= init_n;
      lfsr_en         <= comp_n;
      lfsr_option_sel <= opt_n;
      compute_en      <= comp_n;
      read_en         <= read_n;
      busy            <= (state_n != ST_IDLE);
      done            <= done_n;
      cmd_err         <= err_n;
    end
  end

endmodule

// File: tb/tb_weight_lfsr_seq_ctrl.sv
// Self-checking bench for weight_lfsr_seq_ctrl: table-driven commands, directed
// corner sequences and randomized commands checked against a transaction model.
`timescale 1ns/1ps
module tb_weight_lfsr_seq_ctrl;
  import weight_lfsr_pkg::*;

  localparam int unsigned LEN_W = 16;

  logic               CLK = 1'b0;
  logic               RESET = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic               cmd_opt = 1'b0;
  logic               seed_valid = 1'b0;
  logic               seed_ready;
  logic [N_L-1:0]     seed_data = '0;
  logic               lfsr_load;
  logic [N_L_REG-1:0] lfsr_sel;
  logic [N_L-1:0]     LFSR_REG_INIT;
  logic               lfsr_en, lfsr_option_sel, compute_en, read_en;
  logic [RA_W-1:0]    READ_ADDR;
  logic               busy, done, cmd_err;

  weight_lfsr_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_opt(cmd_opt),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed_data(seed_data),
    .lfsr_load(lfsr_load), .lfsr_sel(lfsr_sel), .LFSR_REG_INIT(LFSR_REG_INIT),
    .lfsr_en(lfsr_en), .lfsr_option_sel(lfsr_option_sel),
    .compute_en(compute_en), .read_en(read_en), .READ_ADDR(READ_ADDR),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Transaction-level reference: how many active cycles a command produces.
  function automatic void model_cmd(input logic [1:0] op, input int unsigned len,
                                    output int unsigned comp_cyc,
                                    output int unsigned read_cyc, output bit err);
    comp_cyc = (op == 2'd1) ? len + 1 : 0;
    read_cyc = (op == 2'd2) ? N_R * FXP : 0;
    err      = (op == 2'd3);
  endfunction

  task automatic run_cmd(input string tag, input logic [1:0] op, input int unsigned len,
                         input bit opt, input int unsigned exp_comp,
                         input int unsigned exp_read, input bit exp_err);
    int unsigned n_comp = 0, n_read = 0, n_err = 0, bad_addr = 0, bad_misc = 0;
    bit got_done = 0, done_clean = 0;
    chk({tag, "_ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_len = LEN_W'(len); cmd_opt = opt;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_len = 16'($urandom); cmd_opt = 1'($urandom);
    for (int unsigned c = 0; c < len + 1000; c++) begin
      if (compute_en) n_comp++;
      if (read_en) begin
        if (int'(READ_ADDR) != int'(n_read)) bad_addr++;
        n_read++;
      end
      if ((compute_en && read_en) || lfsr_load || (lfsr_en != compute_en)) bad_misc++;
      if (lfsr_option_sel != opt) bad_misc++;
      if (cmd_err) n_err++;
      if (done) begin
        got_done   = 1;
        done_clean = !compute_en && !read_en && !busy && cmd_ready && (READ_ADDR == '0);
        break;
      end
      if (!busy || cmd_ready) bad_misc++;
      tick();
    end
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_compute_cycles"}, n_comp, exp_comp);
    chk({tag, "_read_cycles"}, n_read, exp_read);
    chk({tag, "_err_pulses"}, n_err, exp_err);
    chk({tag, "_read_addr_seq_errs"}, bad_addr, 0);
    chk({tag, "_strobe_rule_errs"}, bad_misc, 0);
    chk({tag, "_done_cycle_state"}, done_clean, 1);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_err_one_cycle"}, cmd_err, 0);
  endtask

  logic [N_L-1:0] ld_seed  [N_SEED];
  int unsigned    ld_stall [N_SEED];

  task automatic run_load(input string tag, input bit opt);
    int unsigned w = 0, st, n_pulse = 0, last_pulse = 0, done_cyc = 0;
    int unsigned bad_sel = 0, bad_init = 0, bad_hold = 0, bad_misc = 0, late_load = 0;
    bit got_done = 0;
    chk({tag, "_ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_len = 16'($urandom); cmd_opt = opt;
    tick();
    cmd_valid = 1'b0;
    st = ld_stall[0];
    for (int unsigned c = 0; c < 400; c++) begin
      if (lfsr_load) begin
        if (n_pulse < N_SEED) begin
          if (int'(lfsr_sel) != int'(n_pulse)) bad_sel++;
          if (LFSR_REG_INIT != ld_seed[n_pulse]) bad_init++;
        end
        n_pulse++;
        last_pulse = c;
        if (n_pulse == N_SEED && seed_ready) bad_misc++;
      end else if (n_pulse > 0 && n_pulse <= N_SEED && !done) begin
        if (int'(lfsr_sel) != int'(n_pulse - 1) || LFSR_REG_INIT != ld_seed[n_pulse - 1]) bad_hold++;
      end
      if (compute_en || read_en || lfsr_en || lfsr_option_sel != opt) bad_misc++;
      if (done) begin got_done = 1; done_cyc = c; break; end
      if (!busy) bad_misc++;
      if (w >= N_SEED) begin
        seed_valid = 1'b1; seed_data = 16'($urandom);
      end else if (st == 0) begin
        seed_valid = 1'b1; seed_data = ld_seed[w];
      end else begin
        seed_valid = 1'b0; seed_data = 16'($urandom);
      end
      if (seed_valid && seed_ready) begin
        w++;
        if (w < N_SEED) st = ld_stall[w];
      end else if (!seed_valid && st > 0) begin
        st--;
      end
      tick();
    end
    chk({tag, "_done_seen"}, got_done, 1);
    chk({tag, "_load_pulses"}, n_pulse, N_SEED);
    chk({tag, "_sel_order_errs"}, bad_sel, 0);
    chk({tag, "_init_value_errs"}, bad_init, 0);
    chk({tag, "_stall_hold_errs"}, bad_hold, 0);
    chk({tag, "_misc_errs"}, bad_misc, 0);
    chk({tag, "_done_after_last_load"}, done_cyc, last_pulse + 1);
    chk({tag, "_ready_at_done"}, cmd_ready, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (lfsr_load || seed_ready || busy) late_load++;
    end
    seed_valid = 1'b0;
    chk({tag, "_seed_ignored_in_idle"}, late_load, 0);
  endtask

  typedef struct {
    logic [1:0]  op;
    int unsigned len;
    bit          opt;
    int unsigned exp_comp;
    int unsigned exp_read;
    bit          exp_err;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bit found, got;
    int unsigned n_ready_hi, n_comp;
    vecs[0] = '{op: 2'd1, len: 0,     opt: 1'b0, exp_comp: 1,     exp_read: 0,   exp_err: 1'b0};
    vecs[1] = '{op: 2'd1, len: 9,     opt: 1'b1, exp_comp: 10,    exp_read: 0,   exp_err: 1'b0};
    vecs[2] = '{op: 2'd2, len: 3,     opt: 1'b1, exp_comp: 0,     exp_read: 486, exp_err: 1'b0};
    vecs[3] = '{op: 2'd3, len: 5,     opt: 1'b0, exp_comp: 0,     exp_read: 0,   exp_err: 1'b1};
    vecs[4] = '{op: 2'd3, len: 0,     opt: 1'b1, exp_comp: 0,     exp_read: 0,   exp_err: 1'b1};
    vecs[5] = '{op: 2'd1, len: 65535, opt: 1'b1, exp_comp: 65536, exp_read: 0,   exp_err: 1'b0};

    // Reset state: every output low while RESET is held.
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {lfsr_load, lfsr_en, compute_en, read_en, done, cmd_err, seed_ready}, 0);
    chk("rst_read_addr", READ_ADDR, 0);
    RESET = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk("rel_busy", busy, 0);

    foreach (vecs[i])
      run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].len, vecs[i].opt,
              vecs[i].exp_comp, vecs[i].exp_read, vecs[i].exp_err);

    // Seed load with two 2-cycle stalls.
    for (int unsigned w = 0; w < N_SEED; w++) begin
      ld_seed[w]  = 16'(32'hA000 + w);
      ld_stall[w] = (w == 3 || w == 17) ? 2 : 0;
    end
    run_load("load_a000", 1'b1);

    // cmd_valid held through a compute run; the waiting READ goes in after done.
    chk("hold_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_COMPUTE; cmd_len = 16'd20; cmd_opt = 1'b0;
    tick();
    cmd_op = OP_READ;
    n_ready_hi = 0; n_comp = 0; got = 0;
    for (int c = 0; c < 100; c++) begin
      if (done) begin got = 1; break; end
      if (cmd_ready) n_ready_hi++;
      if (compute_en) n_comp++;
      tick();
    end
    chk("hold_done_seen", got, 1);
    chk("hold_ready_low_cycles", n_ready_hi, 0);
    chk("hold_compute_cycles", n_comp, 21);
    chk("hold_ready_at_done", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("hold_second_read_en", read_en, 1);
    chk("hold_second_busy", busy, 1);
    chk("hold_second_addr", READ_ADDR, 0);
    got = 0;
    for (int c = 0; c < 600; c++) begin
      if (done) begin got = 1; break; end
      tick();
    end
    chk("hold_second_done", got, 1);
    tick();

    // Reset in the middle of a read sweep.
    chk("mid_rst_ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_READ; cmd_opt = 1'b1;
    tick();
    cmd_valid = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (READ_ADDR == RA_W'(100)) begin found = 1; break; end
      tick();
    end
    chk("mid_rst_reach_addr100", found, 1);
    RESET = 1'b1;
    tick();
    chk("mid_rst_read_en", read_en, 0);
    chk("mid_rst_read_addr", READ_ADDR, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_opt", lfsr_option_sel, 0);
    RESET = 1'b0;
    tick();
    chk("mid_rst_ready_after", cmd_ready, 1);
    chk("mid_rst_no_done", done, 0);

    // Randomized commands against the transaction model.
    for (int r = 0; r < 12; r++) begin
      logic [1:0]  op;
      int unsigned len, ec, er;
      bit          ee, opt;
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 40);
      opt = 1'($urandom);
      if (op == 2'd0) begin
        for (int unsigned w = 0; w < N_SEED; w++) begin
          ld_seed[w]  = 16'($urandom);
          ld_stall[w] = $urandom_range(0, 2);
        end
        run_load($sformatf("rnd%0d_load", r), opt);
      end else begin
        model_cmd(op, len, ec, er, ee);
        run_cmd($sformatf("rnd%0d_op%0d", r, op), op, len, opt, ec, er, ee);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
